// File: rtl/bm_xfer.sv
// Bitmap transfer engine: moves one 1536-bit bitmap register to or from 96 consecutive
// memory words over a req/ack port, committing loads to the register file atomically.
module bm_xfer #(
    parameter int unsigned W     = 16,
    parameter int unsigned WORDS = 96,
    parameter int unsigned B     = W * WORDS
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_dir,
    input  logic [1:0]   i_bm_sel,
    input  logic [15:0]  i_base_addr,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_mem_req,
    output logic         o_mem_we,
    output logic [15:0]  o_mem_addr,
    output logic [W-1:0] o_mem_wdata,
    input  logic         i_mem_ack,
    input  logic [W-1:0] i_mem_rdata,
    output logic [1:0]   o_rbm_addr,
    input  logic [B-1:0] i_rbm_data,
    output logic [1:0]   o_wbm_addr,
    output logic [B-1:0] o_wbm_data,
    output logic         o_wbm
);

    localparam int unsigned CW = $clog2(WORDS + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSnap,
        StXfer,
        StCommit,
        StFin
    } state_t;

    state_t          r_state;
    state_t          w_state_d;
    logic            r_dir;
    logic [1:0]      r_sel;
    logic [15:0]     r_base;
    logic [CW-1:0]   r_cnt;
    logic [B-1:0]    r_buf;

    logic            w_accept;
    logic            w_beat;
    logic            w_last;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_beat   = (r_state == StXfer) && i_mem_ack;
    assign w_last   = w_beat && (r_cnt == CW'(WORDS - 1));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (i_start) w_state_d = i_dir ? StSnap : StXfer;
            StSnap:   w_state_d = StXfer;
            StXfer:   if (w_last) w_state_d = r_dir ? StFin : StCommit;
            StCommit: w_state_d = StIdle;
            StFin:    w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_dir   <= 1'b0;
            r_sel   <= 2'd0;
            r_base  <= 16'h0000;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_dir  <= i_dir;
                r_sel  <= (i_bm_sel == 2'd3) ? 2'd0 : i_bm_sel;
                r_base <= i_base_addr;
                r_cnt  <= '0;
            end
            if (r_state == StSnap) begin
                r_buf <= i_rbm_data;
            end
            // Loads shift new words in at the top so word 0 lands at the bottom after 96 beats.
            if (w_beat) begin
                r_cnt <= r_cnt + CW'(1);
                r_buf <= r_dir ? (r_buf >> W) : {i_mem_rdata, r_buf[B-1:W]};
            end
        end
    end

    always_comb begin
        o_busy      = (r_state != StIdle);
        o_done      = (r_state == StCommit) || (r_state == StFin);
        o_mem_req   = (r_state == StXfer);
        o_mem_we    = (r_state == StXfer) && r_dir;
        o_mem_addr  = r_base + 16'(r_cnt);
        o_mem_wdata = r_buf[W-1:0];
        o_rbm_addr  = (r_state == StIdle) ? 2'd0 : r_sel;
        o_wbm_addr  = r_sel;
        o_wbm_data  = r_buf;
        o_wbm       = (r_state == StCommit);
    end

endmodule

// File: tb/tb_bm_xfer.sv
// Bench for bm_xfer: memory and register-file models with random ack stalls, checked against
// expected transfers computed directly from the word/address mapping.
module tb_bm_xfer;

    localparam int W     = 16;
    localparam int WORDS = 96;
    localparam int B     = W * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dir;
    logic [1:0]    bm_sel;
    logic [15:0]   base_addr;
    logic          busy;
    logic          done;
    logic          mem_req;
    logic          mem_we;
    logic [15:0]   mem_addr;
    logic [W-1:0]  mem_wdata;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic [1:0]    rbm_addr;
    logic [B-1:0]  rbm_data;
    logic [1:0]    wbm_addr;
    logic [B-1:0]  wbm_data;
    logic          wbm;

    bm_xfer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_dir       (dir),
        .i_bm_sel    (bm_sel),
        .i_base_addr (base_addr),
        .o_busy      (busy),
        .o_done      (done),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .o_rbm_addr  (rbm_addr),
        .i_rbm_data  (rbm_data),
        .o_wbm_addr  (wbm_addr),
        .o_wbm_data  (wbm_data),
        .o_wbm       (wbm)
    );

    always #5 clk = ~clk;

    logic [15:0]  mem [0:65535];
    logic [B-1:0] rf  [0:3];
    assign rbm_data = rf[rbm_addr];

    int total = 0;
    int bad   = 0;

    int           cyc = 0;
    int           t_start = -1000;
    bit           timed_out;
    int           max_stall = 0;
    int           wbm_n, done_n, busy_n, hold_viol;
    int           wbm_cyc, done_cyc;
    logic [1:0]   wbm_addr_s, snap_rbm, xfer_rbm;
    logic [B-1:0] wbm_data_s;
    logic [15:0]  rd_q[$];
    logic [15:0]  wr_a_q[$];
    logic [15:0]  wr_d_q[$];

    // Memory responder: random stall per beat, junk acks while no request is pending.
    int wait_left = 0;
    bit fresh = 1'b1;
    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
            fresh     = 1'b1;
        end else begin
            if (fresh) begin
                wait_left = int'($urandom_range(0, max_stall));
                fresh     = 1'b0;
            end
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                fresh     = 1'b1;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                wait_left--;
            end
        end
    end

    logic        hold_valid = 1'b0;
    logic [15:0] hold_addr, hold_wdata;
    logic        hold_we;
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_req && hold_valid &&
                (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata))
                hold_viol++;
            hold_valid = mem_req && !mem_ack;
            hold_addr  = mem_addr;
            hold_we    = mem_we;
            hold_wdata = mem_wdata;
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_a_q.push_back(mem_addr);
                    wr_d_q.push_back(mem_wdata);
                end else begin
                    rd_q.push_back(mem_addr);
                end
            end
            if (wbm) begin
                wbm_n++;
                wbm_cyc    = cyc;
                wbm_addr_s = wbm_addr;
                wbm_data_s = wbm_data;
                rf[wbm_addr] = wbm_data;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (busy) busy_n++;
            if (cyc == t_start + 1) snap_rbm = rbm_addr;
            if (cyc == t_start + 2) xfer_rbm = rbm_addr;
        end else begin
            hold_valid = 1'b0;
        end
    end

    task automatic clear_mon();
        wbm_n = 0; done_n = 0; busy_n = 0; hold_viol = 0;
        wbm_cyc = -1; done_cyc = -1;
        snap_rbm = 2'bxx; xfer_rbm = 2'bxx;
        rd_q.delete(); wr_a_q.delete(); wr_d_q.delete();
    endtask

    // Called at a negedge while idle; returns at the negedge of the cycle after done.
    task automatic do_cmd(input bit d, input logic [1:0] s, input logic [15:0] b, input bit noise);
        clear_mon();
        dir = d; bm_sel = s; base_addr = b; start = 1'b1;
        t_start = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (done_n > 0) begin
                timed_out = 1'b0;
                break;
            end
            if (noise) begin
                start = 1'($urandom); dir = 1'($urandom);
                bm_sel = 2'($urandom); base_addr = 16'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic rand_bitmap(output logic [B-1:0] v);
        for (int k = 0; k < WORDS; k++) v[16*k +: 16] = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir = 1'b0; bm_sel = 2'd0; base_addr = 16'h0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, mem_req, mem_we, wbm} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000", {busy, done, mem_req, mem_we, wbm});
        end
        total++;
        if ({mem_addr, mem_wdata} !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem got=%h want=0", {mem_addr, mem_wdata});
        end
        total++;
        if ({wbm_addr, rbm_addr} !== 4'h0) begin
            bad++;
            $display("FAIL reset_bm_addr got=%h want=0", {wbm_addr, rbm_addr});
        end
        total++;
        if (wbm_data !== '0) begin
            bad++;
            $display("FAIL reset_wbm_data got_nonzero want=0");
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_basic();
        logic [B-1:0] exp_v;
        int nerr, fw;
        for (int i = 0; i < WORDS; i++) begin
            mem[16'h0100 + i] = 16'(i + 1);
            exp_v[16*i +: 16] = 16'(i + 1);
        end
        max_stall = 0;
        do_cmd(1'b0, 2'd1, 16'h0100, 1'b0);
        total++;
        if (timed_out !== 1'b0) begin bad++; $display("FAIL load_timeout got=1 want=0"); end
        total++;
        if (wbm_n != 1 || wbm_cyc != t_start + 97) begin
            bad++; $display("FAIL load_wbm_time got=n%0d@%0d want=n1@%0d", wbm_n, wbm_cyc, t_start + 97);
        end
        total++;
        if (done_n != 1 || done_cyc != t_start + 97) begin
            bad++; $display("FAIL load_done_time got=n%0d@%0d want=n1@%0d", done_n, done_cyc, t_start + 97);
        end
        total++;
        if (wbm_addr_s !== 2'd1) begin bad++; $display("FAIL load_wbm_addr got=%0d want=1", wbm_addr_s); end
        total++;
        if (wbm_data_s[15:0] !== 16'd1 || wbm_data_s[1535:1520] !== 16'd96) begin
            bad++; $display("FAIL load_ends got=%h/%h want=0001/0060", wbm_data_s[15:0], wbm_data_s[1535:1520]);
        end
        nerr = 0; fw = 0;
        for (int i = 0; i < WORDS; i++)
            if (wbm_data_s[16*i +: 16] !== exp_v[16*i +: 16]) begin if (nerr == 0) fw = i; nerr++; end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL load_data wrong=%0d word%0d got=%h want=%h", nerr, fw, wbm_data_s[16*fw +: 16], exp_v[16*fw +: 16]);
        end
        total++;
        if (rd_q.size() != WORDS || wr_a_q.size() != 0) begin
            bad++; $display("FAIL load_beats got=r%0d/w%0d want=r96/w0", rd_q.size(), wr_a_q.size());
        end
        total++;
        if (busy_n != 97) begin bad++; $display("FAIL load_busy_cycles got=%0d want=97", busy_n); end
    endtask

    task automatic test_store();
        int nerr, fw;
        for (int i = 0; i < WORDS; i++) rf[2][16*i +: 16] = 16'hA000 + 16'(i);
        max_stall = 0;
        do_cmd(1'b1, 2'd2, 16'h2000, 1'b0);
        total++;
        if (timed_out !== 1'b0) begin bad++; $display("FAIL store_timeout got=1 want=0"); end
        total++;
        if (done_n != 1 || done_cyc != t_start + 98) begin
            bad++; $display("FAIL store_done_time got=n%0d@%0d want=n1@%0d", done_n, done_cyc, t_start + 98);
        end
        total++;
        if (wbm_n != 0) begin bad++; $display("FAIL store_wbm got=%0d want=0", wbm_n); end
        total++;
        if (wr_a_q.size() != WORDS || rd_q.size() != 0) begin
            bad++; $display("FAIL store_beats got=w%0d/r%0d want=w96/r0", wr_a_q.size(), rd_q.size());
        end
        nerr = 0; fw = 0;
        for (int i = 0; i < wr_a_q.size(); i++)
            if (wr_a_q[i] !== 16'h2000 + 16'(i) || wr_d_q[i] !== 16'hA000 + 16'(i)) begin
                if (nerr == 0) fw = i; nerr++;
            end
        total++;
        if (nerr != 0) begin
            bad++; $display("FAIL store_writes wrong=%0d beat%0d got=%h:%h want=%h:%h", nerr, fw, wr_a_q[fw], wr_d_q[fw], 16'h2000 + 16'(fw), 16'hA000 + 16'(fw));
        end
        total++;
        if (snap_rbm !== 2'd2) begin bad++; $display("FAIL store_snap_rbm got=%0d want=2", snap_rbm); end
        total++;
        if (busy_n != 98) begin bad++; $display("FAIL store_busy_cycles got=%0d want=98", busy_n); end
    endtask

    task automatic test_wrap();
        logic [B-1:0] exp_v;
        logic [15:0]  a;
        int nerr, fw;
        for (int i = 0; i < WORDS; i++) begin
            a = 16'hFFF0 + 16'(i);
            mem[a] = 16'($urandom);
            exp_v[16*i +: 16] = mem[a];
        end
        max_stall = 0;
        do_cmd(1'b0, 2'd0, 16'hFFF0, 1'b0);
        total++;
        if (timed_out !== 1'b0 || rd_q.size() != WORDS) begin
            bad++; $display("FAIL wrap_beats got=%0d want=96", rd_q.size());
        end
        nerr = 0; fw = 0;
        for (int i = 0; i < rd_q.size(); i++) begin
            a = (i < 16) ? 16'hFFF0 + 16'(i) : 16'(i - 16);
            if (rd_q[i] !== a) begin if (nerr == 0) fw = i; nerr++; end
        end
        total++;
        if (nerr != 0) begin bad++; $display("FAIL wrap_addr wrong=%0d beat%0d got=%h", nerr, fw, rd_q[fw]); end
        total++;
        if (wbm_data_s !== exp_v || wbm_addr_s !== 2'd0) begin
            bad++; $display("FAIL wrap_data got_w0=%h want_w0=%h", wbm_data_s[15:0], exp_v[15:0]);
        end
    endtask

    task automatic test_stall();
        logic [B-1:0] exp_v, ref_v;
        logic [15:0]  b, a;
        logic [1:0]   s, es;
        bit           d;
        int           nerr;
        b = 16'($urandom);
        for (int i = 0; i < WORDS; i++) begin a = b + 16'(i); mem[a] = 16'($urandom); end
        max_stall = 0;
        do_cmd(1'b0, 2'd3, b, 1'b0);
        ref_v = wbm_data_s;
        max_stall = 3;
        do_cmd(1'b0, 2'd3, b, 1'b1);
        total++;
        if (timed_out !== 1'b0 || wbm_data_s !== ref_v || wbm_addr_s !== 2'd0) begin
            bad++; $display("FAIL stall_vs_zero_wait got_w0=%h want_w0=%h", wbm_data_s[15:0], ref_v[15:0]);
        end
        for (int it = 0; it < 6; it++) begin
            d = 1'($urandom); s = 2'($urandom); b = 16'($urandom);
            es = (s == 2'd3) ? 2'd0 : s;
            if (d) begin
                rand_bitmap(exp_v);
                rf[es] = exp_v;
            end else begin
                for (int i = 0; i < WORDS; i++) begin
                    a = b + 16'(i); mem[a] = 16'($urandom); exp_v[16*i +: 16] = mem[a];
                end
            end
            do_cmd(d, s, b, 1'b1);
            total++;
            if (timed_out !== 1'b0 || done_n != 1 || hold_viol != 0) begin
                bad++; $display("FAIL stall_run%0d got=to%0d/done%0d/hold%0d want=0/1/0", it, timed_out, done_n, hold_viol);
            end
            nerr = 0;
            if (d) begin
                if (wr_a_q.size() != WORDS || wbm_n != 0) nerr++;
                for (int i = 0; i < wr_a_q.size(); i++)
                    if (wr_a_q[i] !== b + 16'(i) || wr_d_q[i] !== exp_v[16*i +: 16]) nerr++;
            end else begin
                if (wbm_n != 1 || wbm_addr_s !== es || wbm_data_s !== exp_v) nerr++;
            end
            total++;
            if (nerr != 0) begin bad++; $display("FAIL stall_result%0d dir=%0d errors=%0d want=0", it, d, nerr); end
            @(negedge clk);
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL stall_start_ignored%0d busy got=%b want=0", it, busy); end
        end
        max_stall = 0;
    endtask

    task automatic test_reset_abort();
        logic [B-1:0] exp_v, old_v;
        logic [15:0]  a;
        bit           reached;
        for (int i = 0; i < WORDS; i++) begin
            a = 16'h4000 + 16'(i); mem[a] = 16'($urandom); exp_v[16*i +: 16] = mem[a];
        end
        rand_bitmap(old_v);
        rf[1] = old_v;
        max_stall = 0;
        clear_mon();
        dir = 1'b0; bm_sel = 2'd1; base_addr = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (rd_q.size() >= 40) begin reached = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!reached) begin bad++; $display("FAIL abort_reach_beat40 got=%0d want=40", rd_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_next got=req%b/busy%b want=0/0", mem_req, busy);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (wbm_n != 0 || done_n != 0 || rf[1] !== old_v) begin
            bad++; $display("FAIL abort_no_commit got=wbm%0d/done%0d want=0/0", wbm_n, done_n);
        end
        do_cmd(1'b0, 2'd1, 16'h4000, 1'b0);
        total++;
        if (timed_out !== 1'b0 || wbm_n != 1 || wbm_cyc != t_start + 97 || wbm_data_s !== exp_v) begin
            bad++; $display("FAIL abort_reload got=n%0d@%0d w0=%h want=n1@%0d w0=%h", wbm_n, wbm_cyc, wbm_data_s[15:0], t_start + 97, exp_v[15:0]);
        end
    endtask

    task automatic test_sel3();
        logic [B-1:0] v0, v3;
        int nerr;
        rand_bitmap(v0);
        rand_bitmap(v3);
        rf[0] = v0;
        rf[3] = v3;
        do_cmd(1'b1, 2'd3, 16'h7000, 1'b0);
        total++;
        if (snap_rbm !== 2'd0 || xfer_rbm !== 2'd0) begin
            bad++; $display("FAIL sel3_rbm got=%0d/%0d want=0/0", snap_rbm, xfer_rbm);
        end
        nerr = (wr_a_q.size() != WORDS) ? 1 : 0;
        for (int i = 0; i < wr_a_q.size(); i++)
            if (wr_a_q[i] !== 16'h7000 + 16'(i) || wr_d_q[i] !== v0[16*i +: 16]) nerr++;
        total++;
        if (timed_out !== 1'b0 || nerr != 0) begin bad++; $display("FAIL sel3_writes errors=%0d want=0", nerr); end
    endtask

    task automatic test_back_to_back();
        logic [B-1:0] exp_v;
        logic [15:0]  a;
        int first_done, nerr;
        for (int i = 0; i < WORDS; i++) begin
            a = 16'h9000 + 16'(i); mem[a] = 16'($urandom); exp_v[16*i +: 16] = mem[a];
        end
        do_cmd(1'b0, 2'd2, 16'h9000, 1'b0);
        first_done = done_cyc;
        do_cmd(1'b1, 2'd2, 16'hB000, 1'b0);
        total++;
        if (t_start != first_done + 1 || done_cyc != t_start + 98) begin
            bad++; $display("FAIL b2b_timing got=start%0d/done%0d want=%0d/%0d", t_start, done_cyc, first_done + 1, first_done + 99);
        end
        nerr = (wr_a_q.size() != WORDS) ? 1 : 0;
        for (int i = 0; i < wr_a_q.size(); i++)
            if (wr_a_q[i] !== 16'hB000 + 16'(i) || wr_d_q[i] !== exp_v[16*i +: 16]) nerr++;
        total++;
        if (timed_out !== 1'b0 || nerr != 0) begin bad++; $display("FAIL b2b_data errors=%0d want=0", nerr); end
    endtask

    initial begin
        for (int r = 0; r < 4; r++) rf[r] = '0;
        clear_mon();
        test_reset();
        test_load_basic();
        test_store();
        test_wrap();
        test_stall();
        test_reset_abort();
        test_sel3();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
